// File: rtl/hazard_stall_controller_if.sv
// Hazard/freeze control bundle between the pipeline datapath and the
// hazard_stall_controller. master = pipeline side, slave = controller side.
interface hazard_stall_controller_if #(
    parameter int unsigned REG_W = 5
);
    // ID operands and EXE/MEM producer information
    logic [REG_W-1:0] src1_ID;
    logic [REG_W-1:0] src2_ID;
    logic             two_src_ID;
    logic [REG_W-1:0] dest_EXE;
    logic             WB_EN_EXE;
    logic             MEM_R_EN_EXE;
    logic [REG_W-1:0] dest_MEM;
    logic             WB_EN_MEM;
    logic             forward_en;
    logic             mem_busy;
    logic             branch_taken;

    // Pipeline register controls and status
    logic             freeze_pc;
    logic             freeze_ifid;
    logic             bubble_idex;
    logic             freeze_all;
    logic             flush;
    logic [15:0]      stall_cycles;
    logic             mem_timeout_err;

    modport master (
        output src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_EN_MEM, forward_en, mem_busy, branch_taken,
        input  freeze_pc, freeze_ifid, bubble_idex, freeze_all, flush,
               stall_cycles, mem_timeout_err
    );

    modport slave (
        input  src1_ID, src2_ID, two_src_ID, dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_EN_MEM, forward_en, mem_busy, branch_taken,
        output freeze_pc, freeze_ifid, bubble_idex, freeze_all, flush,
               stall_cycles, mem_timeout_err
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: RAW hazard stalls/bubbles, whole-pipe
// freeze on SRAM busy with a watchdog, and branch flush ordering.
module hazard_stall_controller #(
    parameter int unsigned REG_W       = 5,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    hazard_stall_controller_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state;
    logic [7:0]       wait_cnt;
    logic             err;
    logic [15:0]      stall_cnt;

    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic [REG_W-1:0] dexe;
    logic [REG_W-1:0] dmem;
    logic             hzd_exe;
    logic             hzd_mem;
    logic             stall_cond;
    logic             freeze_all_c;
    logic             hazard_stall;

    assign src1 = bus.src1_ID;
    assign src2 = bus.src2_ID;
    assign dexe = bus.dest_EXE;
    assign dmem = bus.dest_MEM;

    // Hazard detection and zero-latency control decode; everything is held
    // low while reset is asserted.
    always_comb begin
        hzd_exe = bus.WB_EN_EXE &
                  ((src1 == dexe) | (bus.two_src_ID & (src2 == dexe)));
        hzd_mem = bus.WB_EN_MEM &
                  ((src1 == dmem) | (bus.two_src_ID & (src2 == dmem)));
        stall_cond   = bus.forward_en ? (hzd_exe & bus.MEM_R_EN_EXE)
                                      : (hzd_exe | hzd_mem);
        freeze_all_c = ~rst & ((state == ERROR) | bus.mem_busy);
        // A taken branch discards the ID instruction, so it wins over a stall.
        hazard_stall = ~rst & stall_cond & ~freeze_all_c & ~bus.branch_taken;
    end

    assign bus.freeze_all      = freeze_all_c;
    assign bus.bubble_idex     = hazard_stall;
    assign bus.freeze_pc       = hazard_stall | freeze_all_c;
    assign bus.freeze_ifid     = hazard_stall | freeze_all_c;
    assign bus.flush           = ~rst & bus.branch_taken & ~freeze_all_c;
    assign bus.stall_cycles    = rst ? '0 : stall_cnt;
    assign bus.mem_timeout_err = ~rst & err;

    // Memory-wait FSM with watchdog; ERROR is terminal until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (!bus.mem_busy) begin
                        state <= RUN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ERROR;
                        err   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles spent in a hazard stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
